// File: rtl/adc_conversion_sequencer_pkg.sv
// Shared definitions for the ADC conversion sequencer: FSM state encoding,
// status-counter limits and default parameter values.
package adc_conversion_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CNV     = 3'd1,
      ST_WAIT_HI = 3'd2,
      ST_WAIT_LO = 3'd3,
      ST_READ    = 3'd4
   } state_t;

   localparam logic [15:0] OVERRUN_MAX            = 16'hFFFF;
   localparam int          DEFAULT_TIMEOUT_CYCLES = 1000;
   localparam int          DEFAULT_SYNC_STAGES    = 2;

   // Saturating increment used by the dropped-trigger counter
   function automatic logic [15:0] sat_inc16(input logic [15:0] value);
      return (value == OVERRUN_MAX) ? value : value + 16'd1;
   endfunction

endpackage

// File: rtl/adc_busy_sync.sv
// Multi-stage synchronizer bringing the asynchronous ADC BUSY line into the
// aclk domain; all stages reset to 0.
module adc_busy_sync
   import adc_conversion_sequencer_pkg::*;
#(
   parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic busy,
   output logic busy_s
);

   logic [SYNC_STAGES-1:0] sync_q;

   if (SYNC_STAGES < 2) begin : g_bad_stages
      $error("adc_busy_sync: SYNC_STAGES must be at least 2");
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], busy};
      end
   end

   assign busy_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/adc_conversion_sequencer.sv
// One ADC conversion per trigger: CNV pulse, BUSY handshake, readout request.
// Define ADC_TIMEOUT_EN to enable the per-phase BUSY timeout and timeout_err.
module adc_conversion_sequencer
   import adc_conversion_sequencer_pkg::*;
#(
   parameter int CNV_W_BITS     = 8,
   parameter int SYNC_STAGES    = DEFAULT_SYNC_STAGES,
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  enable,
   input  logic                  trigger,
   input  logic [CNV_W_BITS-1:0] cnv_width,
   input  logic                  clr_status,
   output logic                  cnv,
   input  logic                  busy,
   output logic                  rd_start,
   input  logic                  rd_done,
   output logic                  active,
   output logic [15:0]           overrun_cnt,
   output logic [31:0]           sample_cnt,
   output logic                  timeout_err
);

   state_t                state_q;
   state_t                state_d;
   logic [CNV_W_BITS-1:0] width_cnt_q;
   logic                  busy_s;
   logic                  sample_done;

`ifdef ADC_TIMEOUT_EN
   localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TMO_W-1:0] tmo_cnt_q;
   logic             tmo_expired;
   logic             tmo_fire;
   logic             timeout_q;
`endif

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("adc_conversion_sequencer: TIMEOUT_CYCLES must be at least 1");
   end

   adc_busy_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_busy_sync (
      .aclk    (aclk),
      .aresetn (aresetn),
      .busy    (busy),
      .busy_s  (busy_s)
   );

   always_comb begin
      state_d     = state_q;
      sample_done = 1'b0;
`ifdef ADC_TIMEOUT_EN
      tmo_fire    = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (trigger && enable) state_d = ST_CNV;
         end
         ST_CNV: begin
            if (width_cnt_q == CNV_W_BITS'(1)) state_d = ST_WAIT_HI;
         end
         // The awaited BUSY level always takes priority over an expiring timeout
         ST_WAIT_HI: begin
            if (busy_s) state_d = ST_WAIT_LO;
`ifdef ADC_TIMEOUT_EN
            else if (tmo_expired) begin
               state_d  = ST_IDLE;
               tmo_fire = 1'b1;
            end
`endif
         end
         ST_WAIT_LO: begin
            if (!busy_s) state_d = ST_READ;
`ifdef ADC_TIMEOUT_EN
            else if (tmo_expired) begin
               state_d  = ST_IDLE;
               tmo_fire = 1'b1;
            end
`endif
         end
         ST_READ: begin
            if (rd_done) begin
               state_d     = ST_IDLE;
               sample_done = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Width is re-latched every IDLE cycle, so the value seen on the accepting edge sticks
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         cnv         <= 1'b0;
         rd_start    <= 1'b0;
         width_cnt_q <= '0;
      end else begin
         cnv      <= (state_d == ST_CNV);
         rd_start <= (state_d == ST_READ) && (state_q != ST_READ);
         if (state_q == ST_IDLE) begin
            width_cnt_q <= (cnv_width == '0) ? CNV_W_BITS'(1) : cnv_width;
         end else if (state_q == ST_CNV) begin
            width_cnt_q <= width_cnt_q - CNV_W_BITS'(1);
         end
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overrun_cnt <= '0;
         sample_cnt  <= '0;
      end else begin
         if (clr_status) begin
            overrun_cnt <= '0;
         end else if (trigger && (state_q != ST_IDLE)) begin
            overrun_cnt <= sat_inc16(overrun_cnt);
         end
         sample_cnt <= sample_cnt + 32'(sample_done);
      end
   end

   assign active = (state_q != ST_IDLE);

`ifdef ADC_TIMEOUT_EN
   assign tmo_expired = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

   // Restarts on every state change so each BUSY phase gets a full budget
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         tmo_cnt_q <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state_d != state_q) begin
            tmo_cnt_q <= '0;
         end else if ((state_q == ST_WAIT_HI) || (state_q == ST_WAIT_LO)) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
         end
         if (clr_status) begin
            timeout_q <= 1'b0;
         end else if (tmo_fire) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_q;
`else
   assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Self-checking bench for adc_conversion_sequencer: directed and randomized
// conversions compared against a transaction-level model of the sequencing rules.
module tb_adc_conversion_sequencer;

   localparam int SYNC = 2;
   localparam int TMO  = 50;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic        enable;
   logic        trigger;
   logic [7:0]  cnv_width;
   logic        clr_status;
   logic        cnv;
   logic        busy;
   logic        rd_start;
   logic        rd_done;
   logic        active;
   logic [15:0] overrun_cnt;
   logic [31:0] sample_cnt;
   logic        timeout_err;

   int total = 0;
   int bad   = 0;
   int exp_samples = 0;
   int exp_overrun = 0;

   adc_conversion_sequencer #(
      .CNV_W_BITS     (8),
      .SYNC_STAGES    (SYNC),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .enable      (enable),
      .trigger     (trigger),
      .cnv_width   (cnv_width),
      .clr_status  (clr_status),
      .cnv         (cnv),
      .busy        (busy),
      .rd_start    (rd_start),
      .rd_done     (rd_done),
      .active      (active),
      .overrun_cnt (overrun_cnt),
      .sample_cnt  (sample_cnt),
      .timeout_err (timeout_err)
   );

   always #5 aclk = ~aclk;

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic applyStimulus(input logic trig, input logic en, input logic [7:0] width,
                                input logic bsy, input logic done, input logic clr);
      trigger    = trig;
      enable     = en;
      cnv_width  = width;
      busy       = bsy;
      rd_done    = done;
      clr_status = clr;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One complete conversion. Sample k is taken 1ns after the k-th edge following
   // the edge that accepts the trigger; inputs set at sample k are seen at edge k+1.
   // trig_mode: 0 none, 1 random extra triggers, 2 three extra triggers,
   // 3 extra trigger then trigger coincident with clr_status.
   task automatic run_conversion(input int w, input int bdelay, input int blen, input int rdelay,
                                 input int trig_mode, input bit en_drop, input bit width_change);
      int n, k_rd, k_done, cnv_hi, rd_cnt, rd_first;
      logic trig_n, clr_n, en_n;
      logic [7:0] width_n;
      n      = (w == 0) ? 1 : w;
      k_rd   = bdelay + blen + SYNC + 1;
      k_done = k_rd + rdelay + 1;
      cnv_hi = 0;
      rd_cnt = 0;
      rd_first = -1;
      en_n    = 1'b1;
      width_n = w[7:0];
      applyStimulus(1'b1, 1'b1, w[7:0], 1'b0, 1'b0, 1'b0);
      for (int k = 0; k <= k_done; k++) begin
         tick();
         if (cnv === 1'b1) cnv_hi++;
         if (rd_start === 1'b1) begin
            rd_cnt++;
            if (rd_first < 0) rd_first = k;
         end
         if (k == 0) begin
            checkOutput("cnv_rise", cnv, 1);
            checkOutput("active_start", active, 1);
         end
         trig_n = 1'b0;
         clr_n  = 1'b0;
         if (trig_mode == 1 && k >= 1 && k < k_rd) trig_n = ($urandom_range(0, 3) == 0);
         if (trig_mode == 2 && k >= 1 && k <= 3) trig_n = 1'b1;
         if (trig_mode == 3 && k == 1) trig_n = 1'b1;
         if (trig_mode == 3 && k == 2) begin
            trig_n = 1'b1;
            clr_n  = 1'b1;
         end
         if (clr_n) exp_overrun = 0;
         else if (trig_n && exp_overrun < 65535) exp_overrun++;
         if (en_drop && k >= 1) en_n = 1'b0;
         if (width_change && k == 1) width_n = 8'($urandom_range(0, 255));
         applyStimulus(trig_n, en_n, width_n, (k >= bdelay && k < bdelay + blen),
                       (k == k_rd + rdelay), clr_n);
      end
      exp_samples++;
      checkOutput("cnv_high_cycles", cnv_hi, n);
      checkOutput("rd_start_count", rd_cnt, 1);
      checkOutput("rd_start_cycle", rd_first, k_rd);
      checkOutput("active_end", active, 0);
      checkOutput("sample_cnt", sample_cnt, exp_samples);
      checkOutput("overrun_cnt", overrun_cnt, exp_overrun);
   endtask

   initial begin
      int w, n, rd_cnt;
      aresetn = 1'b0;
      applyStimulus(1'b0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0);
      #2;
      checkOutput("reset_cnv", cnv, 0);
      checkOutput("reset_rd_start", rd_start, 0);
      checkOutput("reset_active", active, 0);
      checkOutput("reset_overrun", overrun_cnt, 0);
      checkOutput("reset_samples", sample_cnt, 0);
      checkOutput("reset_timeout", timeout_err, 0);
      tick();
      tick();
      aresetn = 1'b1;
      tick();

      $display("[TB] directed conversions");
      run_conversion(4, 3, 20, 2, 0, 1'b0, 1'b0);
      run_conversion(0, 1, 6, 0, 0, 1'b0, 1'b0);
      run_conversion(3, 2, 10, 1, 2, 1'b0, 1'b0);

      applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1);
      tick();
      exp_overrun = 0;
      applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      checkOutput("overrun_cleared", overrun_cnt, exp_overrun);

      run_conversion(5, 0, 12, 3, 3, 1'b0, 1'b0);

      applyStimulus(1'b1, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b0, 8'd4, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("disabled_trig_active", active, 0);
      checkOutput("disabled_trig_cnv", cnv, 0);
      checkOutput("disabled_trig_overrun", overrun_cnt, exp_overrun);

      applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      tick();
      checkOutput("idle_rd_done_samples", sample_cnt, exp_samples);

      run_conversion(6, 2, 12, 0, 0, 1'b1, 1'b1);

      $display("[TB] randomized conversions");
      for (int i = 0; i < 6; i++) begin
         w = $urandom_range(0, 10);
         n = (w == 0) ? 1 : w;
         run_conversion(w, $urandom_range(0, 5), $urandom_range(n + 3, n + 20),
                        $urandom_range(0, 4), 1, 1'b0, 1'b0);
      end

      $display("[TB] busy never rises");
      rd_cnt = 0;
      applyStimulus(1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
`ifdef ADC_TIMEOUT_EN
      for (int k = 0; k <= 3 + TMO; k++) begin
         tick();
         if (rd_start === 1'b1) rd_cnt++;
         if (k == 3 + TMO - 1) begin
            checkOutput("timeout_not_yet", timeout_err, 0);
            checkOutput("timeout_still_active", active, 1);
         end
         if (k == 3 + TMO) begin
            checkOutput("timeout_flag", timeout_err, 1);
            checkOutput("timeout_to_idle", active, 0);
         end
         applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("timeout_no_rd_start", rd_cnt, 0);
      checkOutput("timeout_samples", sample_cnt, exp_samples);
      applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1);
      tick();
      applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
      checkOutput("timeout_cleared", timeout_err, 0);
      applyStimulus(1'b1, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
`else
      for (int k = 0; k <= 3 + 80; k++) begin
         tick();
         if (rd_start === 1'b1) rd_cnt++;
         applyStimulus(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
      end
      checkOutput("wait_forever_active", active, 1);
      checkOutput("wait_forever_no_timeout", timeout_err, 0);
      checkOutput("wait_forever_no_rd_start", rd_cnt, 0);
      applyStimulus(1'b0, 1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
`endif

      $display("[TB] reset during busy phase");
      repeat (10) tick();
      checkOutput("pre_reset_active", active, 1);
      checkOutput("pre_reset_samples", sample_cnt, exp_samples);
      #3;
      aresetn = 1'b0;
      #1;
      checkOutput("async_reset_cnv", cnv, 0);
      checkOutput("async_reset_active", active, 0);
      checkOutput("async_reset_overrun", overrun_cnt, 0);
      checkOutput("async_reset_samples", sample_cnt, 0);
      checkOutput("async_reset_timeout", timeout_err, 0);
      tick();
      applyStimulus(1'b0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0);
      tick();
      aresetn = 1'b1;
      exp_samples = 0;
      exp_overrun = 0;
      tick();
      run_conversion(2, 1, 8, 1, 0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
